// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM state
// encoding, default latencies and a small op-class helper.
package mdu_defs;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // Multi-cycle ops that occupy the unit; mthi/mtlo complete in one edge.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational datapath: 32x32 product or quotient/remainder from the
// latched operands, packed as {hi, lo}.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  input  logic        is_div,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [65:0] ext_a;
  logic signed [65:0] ext_b;
  logic signed [65:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        divisor;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

  always_comb begin
    ext_a = {{34{is_signed & op_a[31]}}, op_a};
    ext_b = {{34{is_signed & op_b[31]}}, op_b};
    prod  = ext_a * ext_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. 0x80000000/-1 falls out
    // naturally as 0x80000000 rem 0.
    a_neg       = is_signed & op_a[31];
    b_neg       = is_signed & op_b[31];
    a_mag       = a_neg ? (32'd0 - op_a) : op_a;
    b_mag       = b_neg ? (32'd0 - op_b) : op_b;
    div_by_zero = (op_b == 32'd0);
    divisor     = div_by_zero ? 32'd1 : b_mag;
    q_mag       = a_mag / divisor;
    r_mag       = a_mag % divisor;
    quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;

    result = is_div ? {rem, quot} : prod[63:0];
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, models the
// fixed multi-cycle latency and raises a stall request for D-stage MD ops.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  dbg_state
);

  // Handshake: start is a one-cycle request qualified by op; it is accepted
  // only when busy=0 (busy acts as not-ready) and silently dropped otherwise.

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] arith_result;
  logic        arith_dbz;

  mdu_arith u_arith (
    .op_a        (a_q),
    .op_b        (b_q),
    .is_signed   (sgn_q),
    .is_div      (state_q == ST_DIV),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = MUL_CNT;
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op == OP_DIV);
              cnt_d   = DIV_CNT;
              state_d = ST_DIV;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          // A divide by zero burns its latency but leaves HI/LO untouched.
          if (!((state_q == ST_DIV) && arith_dbz)) begin
            hi_d = arith_result[63:32];
            lo_d = arith_result[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign md_stall  = d_is_md & (busy | (start & is_muldiv(op)));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencer sitting beside the E-stage ALU of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E stage and models fixed multi-cycle latency with an internal counter.
- Owns the HI/LO architectural registers.
- Raises a stall request to the hazard unit while a D-stage mult/div-class instruction would collide with an operation in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  E-stage instruction is an MDU op this cycle
- op  input  3  operation code (see package), sampled when start=1
- src_a  input  32  E-stage forwarded rs value
- src_b  input  32  E-stage forwarded rt value
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  output  1  operation in flight
- md_stall  output  1  stall request to hazard unit
- hi  output  32  HI register, read by mfhi through E-stage result mux
- lo  output  32  LO register, read by mflo

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0.
  - Latched operands are cleared and any in-flight result is discarded.
- States:
  - IDLE, MUL, DIV.
  - busy = (state != IDLE), registered.
- IDLE with start=1:
  - MULT/MULTU: latch src_a/src_b and signedness, counter <= MUL_CYCLES, go to MUL.
  - DIV/DIVU: same, with counter <= DIV_CYCLES, go to DIV.
  - MTHI: hi <= src_a at that edge; stay IDLE; busy stays 0.
  - MTLO: lo <= src_a at that edge; stay IDLE; busy stays 0.
  - op=NONE or an undefined code: no effect.
- MUL/DIV:
  - Counter decrements on each edge.
  - On the edge where counter==1, {hi,lo} are written and the state returns to IDLE.
  - busy is therefore high for exactly N cycles after the start edge; new HI/LO are visible in the first cycle busy=0.
- start while busy=1: ignored. No state, operand or HI/LO change. The hazard unit guarantees this cannot occur; the bench checks it anyway.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divide by zero: the operation still takes DIV_CYCLES, then HI and LO are left unchanged.
  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- Results are computed from the latched operands, never from live src_a/src_b.
- md_stall = d_is_md & (busy | (start & op is MULT/MULTU/DIV/DIVU)). Combinational, no latency.
  - A D-stage op behind an E-stage mthi/mtlo is not stalled; the hazard unit handles HI/LO forwarding.
- The HI/LO write on completion and a reset assertion in the same cycle: reset wins.
- hi/lo are registered outputs; there is no combinational path from src_a/src_b to hi/lo.

Decomposition:
- Shared package mdu_defs holds:
  - op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is reserved and treated as NONE.
  - state encoding: IDLE=0, MUL=1, DIV=2.
  - default latency constants.
- Sub-module mdu_arith: purely combinational. Takes the latched operands, signedness and mul/div select; outputs 64-bit {hi_next, lo_next} and a div_by_zero flag.
- mdu_ctrl keeps the FSM, counter, operand latches, HI/LO registers and the stall logic.

Test Plan:
- Reset release, then MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2. A following DIV x/0 -> busy for 10 cycles, hi=2 and lo=14 unchanged.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on back-to-back cycles -> busy stays 0, hi and lo update on each edge.
- MULT started with d_is_md=1 held high -> md_stall=1 in the start cycle and all 5 busy cycles, md_stall=0 in the next cycle.
- Start issued while busy -> ignored, no state or HI/LO change.
- Reset driven low at busy cycle 3 of a DIV -> busy=0, hi=lo=0 immediately (asynchronously); no later write-back after release.
